// File: rtl/axi_can_burst_splitter_if.sv
// AXI4 bundle shared by the upstream and downstream sides of axi_can_burst_splitter.
// master drives AR/AW/W and the R/B ready signals; slave is the mirror view.
interface axi_can_burst_splitter_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;

   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready
   );
endinterface

// File: rtl/axi_can_burst_splitter.sv
// Replays AXI4 bursts as single-beat transactions for a CAN port that only supports len=0.
// Optional macro AXI_CAN_SPLIT_RESP_MERGE_EN: s_bresp is the worst response over all write beats.
module axi_can_burst_splitter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   axi_can_burst_splitter_if.slave  s,
   axi_can_burst_splitter_if.master m
);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rstate_t;

   typedef enum logic [2:0] {
      W_IDLE = 3'd0,
      W_AW   = 3'd1,
      W_W    = 3'd2,
      W_B    = 3'd3,
      W_RSP  = 3'd4
   } wstate_t;

   function automatic logic [ADDR_W-1:0] next_addr(
      input logic [ADDR_W-1:0] addr,
      input logic [7:0]        len,
      input logic [2:0]        size,
      input logic [1:0]        burst
   );
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] incr;
      logic [ADDR_W-1:0] mask;
      step = ADDR_W'(1'b1) << size;
      incr = addr + step;
      mask = ((ADDR_W'(len) + ADDR_W'(1'b1)) << size) - ADDR_W'(1'b1);
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | (incr & mask);
         default: next_addr = incr;
      endcase
   endfunction

`ifdef AXI_CAN_SPLIT_RESP_MERGE_EN
   // DECERR(11) > SLVERR(10) > EXOKAY(01) > OKAY(00) coincides with numeric order.
   function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
      if (a > b) begin
         resp_worst = a;
      end else begin
         resp_worst = b;
      end
   endfunction
`endif

   rstate_t           r_rstate, w_rnext;
   logic              r_arready;
   logic [ID_W-1:0]   r_rid;
   logic [ADDR_W-1:0] r_raddr;
   logic [7:0]        r_rlen;
   logic [2:0]        r_rsize;
   logic [1:0]        r_rburst;
   logic [7:0]        r_rcnt;
   logic              w_ar_hs, w_r_hs, w_rlast;
   logic              w_m_arvalid, w_s_rvalid, w_m_rready;

   wstate_t           r_wstate, w_wnext;
   logic              r_awready;
   logic [ID_W-1:0]   r_wid;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wlen;
   logic [2:0]        r_wsize;
   logic [1:0]        r_wburst;
   logic [7:0]        r_wcnt;
   logic [1:0]        r_bresp;
   logic [1:0]        w_bresp_next;
   logic              w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat;
   logic              w_m_awvalid, w_m_wvalid, w_s_wready, w_m_bready, w_s_bvalid;

   assign w_ar_hs = s.arvalid & r_arready;
   assign w_r_hs  = w_s_rvalid & s.rready;
   assign w_rlast = (r_rcnt == r_rlen);

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rstate <= R_IDLE;
      end else begin
         r_rstate <= w_rnext;
      end
   end

   // Read FSM next-state logic.
   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE: begin
            if (w_ar_hs) w_rnext = R_ADDR;
            else         w_rnext = R_IDLE;
         end
         R_ADDR: begin
            if (m.arready) w_rnext = R_DATA;
            else           w_rnext = R_ADDR;
         end
         R_DATA: begin
            if (w_r_hs) w_rnext = w_rlast ? R_IDLE : R_ADDR;
            else        w_rnext = R_DATA;
         end
         default: w_rnext = R_IDLE;
      endcase
   end

   // Read FSM outputs; R channel is a straight pass-through while a beat is in flight.
   always_comb begin
      w_m_arvalid = 1'b0;
      w_s_rvalid  = 1'b0;
      w_m_rready  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_m_arvalid = 1'b0;
         end
         R_ADDR: begin
            w_m_arvalid = 1'b1;
         end
         R_DATA: begin
            w_s_rvalid = m.rvalid;
            w_m_rready = s.rready;
         end
         default: begin
            w_m_arvalid = 1'b0;
         end
      endcase
   end

   // Read burst context: latched on AR accept, stepped after each non-final R beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arready <= 1'b0;
         r_rid     <= '0;
         r_raddr   <= '0;
         r_rlen    <= 8'd0;
         r_rsize   <= 3'd0;
         r_rburst  <= 2'b00;
         r_rcnt    <= 8'd0;
      end else begin
         r_arready <= (w_rnext == R_IDLE);
         if (w_ar_hs) begin
            r_rid    <= s.arid;
            r_raddr  <= s.araddr;
            r_rlen   <= s.arlen;
            r_rsize  <= s.arsize;
            r_rburst <= s.arburst;
            r_rcnt   <= 8'd0;
         end else if (w_r_hs && !w_rlast) begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_raddr <= next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
         end
      end
   end

   assign s.arready = r_arready;
   assign m.arid    = r_rid;
   assign m.araddr  = r_raddr;
   assign m.arlen   = 8'd0;
   assign m.arsize  = r_rsize;
   assign m.arburst = 2'b01;
   assign m.arvalid = w_m_arvalid;
   assign m.rready  = w_m_rready;
   assign s.rvalid  = w_s_rvalid;
   assign s.rdata   = m.rdata;
   assign s.rresp   = m.rresp;
   assign s.rid     = r_rid;
   assign s.rlast   = w_rlast;

   assign w_aw_hs      = s.awvalid & r_awready;
   assign w_w_hs       = w_m_wvalid & m.wready;
   assign w_b_hs       = w_m_bready & m.bvalid;
   assign w_wlast_beat = (r_wcnt == r_wlen);

`ifdef AXI_CAN_SPLIT_RESP_MERGE_EN
   assign w_bresp_next = resp_worst(r_bresp, m.bresp);
`else
   assign w_bresp_next = m.bresp;
`endif

   // Write FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wstate <= W_IDLE;
      end else begin
         r_wstate <= w_wnext;
      end
   end

   // Write FSM next-state logic.
   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs) w_wnext = W_AW;
            else         w_wnext = W_IDLE;
         end
         W_AW: begin
            if (m.awready) w_wnext = W_W;
            else           w_wnext = W_AW;
         end
         W_W: begin
            if (w_w_hs) w_wnext = W_B;
            else        w_wnext = W_W;
         end
         W_B: begin
            if (w_b_hs) w_wnext = w_wlast_beat ? W_RSP : W_AW;
            else        w_wnext = W_B;
         end
         W_RSP: begin
            if (s.bready) w_wnext = W_IDLE;
            else          w_wnext = W_RSP;
         end
         default: w_wnext = W_IDLE;
      endcase
   end

   // Write FSM outputs.
   always_comb begin
      w_m_awvalid = 1'b0;
      w_m_wvalid  = 1'b0;
      w_s_wready  = 1'b0;
      w_m_bready  = 1'b0;
      w_s_bvalid  = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_m_awvalid = 1'b0;
         end
         W_AW: begin
            w_m_awvalid = 1'b1;
         end
         W_W: begin
            w_m_wvalid = s.wvalid;
            w_s_wready = m.wready;
         end
         W_B: begin
            w_m_bready = 1'b1;
         end
         W_RSP: begin
            w_s_bvalid = 1'b1;
         end
         default: begin
            w_m_awvalid = 1'b0;
         end
      endcase
   end

   // Write burst context and the response reported back upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_awready <= 1'b0;
         r_wid     <= '0;
         r_waddr   <= '0;
         r_wlen    <= 8'd0;
         r_wsize   <= 3'd0;
         r_wburst  <= 2'b00;
         r_wcnt    <= 8'd0;
         r_bresp   <= 2'b00;
      end else begin
         r_awready <= (w_wnext == W_IDLE);
         if (w_aw_hs) begin
            r_wid    <= s.awid;
            r_waddr  <= s.awaddr;
            r_wlen   <= s.awlen;
            r_wsize  <= s.awsize;
            r_wburst <= s.awburst;
            r_wcnt   <= 8'd0;
            r_bresp  <= 2'b00;
         end else if (w_b_hs) begin
            r_bresp <= w_bresp_next;
            if (!w_wlast_beat) begin
               r_wcnt  <= r_wcnt + 8'd1;
               r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
            end
         end
      end
   end

   assign s.awready = r_awready;
   assign m.awid    = r_wid;
   assign m.awaddr  = r_waddr;
   assign m.awlen   = 8'd0;
   assign m.awsize  = r_wsize;
   assign m.awburst = 2'b01;
   assign m.awvalid = w_m_awvalid;
   assign m.wdata   = s.wdata;
   assign m.wstrb   = s.wstrb;
   assign m.wlast   = 1'b1;
   assign m.wvalid  = w_m_wvalid;
   assign s.wready  = w_s_wready;
   assign m.bready  = w_m_bready;
   assign s.bvalid  = w_s_bvalid;
   assign s.bid     = r_wid;
   assign s.bresp   = r_bresp;

endmodule

// File: tb/tb_axi_can_burst_splitter.sv
// Self-checking bench for axi_can_burst_splitter: upstream master and downstream CAN slave models
// with expected addresses, beats and responses queued at stimulus time and popped at the DUT outputs.
module tb_axi_can_burst_splitter;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_can_burst_splitter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) up ();
   axi_can_burst_splitter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dn ();

   axi_can_burst_splitter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (up),
      .m     (dn)
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic [3:0]  id;
      logic        last;
   } r_beat_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ar_q[$];
   logic [31:0] exp_aw_q[$];
   r_beat_t     exp_r_q[$];
   logic [71:0] exp_w_q[$];
   logic [5:0]  exp_b_q[$];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference address sequence, written in modulo form rather than with masks.
   function automatic logic [31:0] model_next(input logic [31:0] a, input int len, input int size,
                                              input logic [1:0] burst);
      longint unsigned la, step, total, base;
      la    = longint'(a);
      step  = longint'(1) << size;
      total = longint'(len + 1) * step;
      if (burst == 2'b00) return a;
      if (burst == 2'b10) begin
         base = la - (la % total);
         return 32'(base + ((la - base + step) % total));
      end
      return 32'(la + step);
   endfunction

   function automatic logic [63:0] rd_pattern(input logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   function automatic logic [1:0] rresp_of(input logic [31:0] a);
      return (a[4:2] == 3'b111) ? 2'b10 : 2'b00;
   endfunction

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                          input logic [1:0] burst, input int stall_beat, input int ar_stall, input int r_stall);
      logic [31:0] a, got_a, e_a;
      r_beat_t     e;
      bit          ok;
      a = addr;
      for (int i = 0; i <= len; i++) begin
         exp_ar_q.push_back(a);
         e.data = rd_pattern(a);
         e.resp = rresp_of(a);
         e.id   = id;
         e.last = (i == len);
         exp_r_q.push_back(e);
         a = model_next(a, len, size, burst);
      end
      up.arid = id; up.araddr = addr; up.arlen = 8'(len); up.arsize = 3'(size); up.arburst = burst;
      up.arvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = up.arready;
         cyc();
      end
      up.arvalid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL ar_accept: s_arready=0 for 20 cycles, required 1"); return;
      end
      for (int i = 0; i <= len; i++) begin
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            if (dn.arvalid === 1'b1) ok = 1'b1;
            else cyc();
         end
         n_cmp++;
         if (!ok) begin
            n_bad++; $display("FAIL m_arvalid_wait beat %0d: not seen in 20 cycles", i); return;
         end
         got_a = dn.araddr;
         if (i == stall_beat) begin
            for (int k = 0; k < ar_stall; k++) begin
               cyc();
               n_cmp++;
               if (dn.arvalid !== 1'b1 || dn.araddr !== got_a) begin
                  n_bad++;
                  $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1 / %h", dn.arvalid, dn.araddr, got_a);
               end
            end
         end
         e_a = exp_ar_q.pop_front();
         n_cmp++;
         if (dn.araddr !== e_a) begin
            n_bad++; $display("FAIL m_araddr beat %0d: got %h, required %h", i, dn.araddr, e_a);
         end
         n_cmp++;
         if ({dn.arid, dn.arlen, dn.arburst, dn.arsize} !== {id, 8'd0, 2'b01, 3'(size)}) begin
            n_bad++;
            $display("FAIL m_ar_ctl beat %0d: id/len/burst/size=%h/%h/%b/%0d, required %h/00/01/%0d",
                     i, dn.arid, dn.arlen, dn.arburst, dn.arsize, id, size);
         end
         dn.arready = 1'b1;
         cyc();
         dn.arready = 1'b0;
         n_cmp++;
         if (dn.arvalid !== 1'b0) begin
            n_bad++; $display("FAIL m_ar_dup beat %0d: arvalid=%b after handshake, required 0", i, dn.arvalid);
         end
         dn.rvalid = 1'b1; dn.rdata = rd_pattern(got_a); dn.rresp = rresp_of(got_a);
         dn.rid = 4'h0; dn.rlast = 1'b0;
         if (i == stall_beat) begin
            for (int k = 0; k < r_stall; k++) begin
               up.rready = 1'b0;
               #1;
               n_cmp++;
               if (up.rvalid !== 1'b1 || dn.rready !== 1'b0) begin
                  n_bad++;
                  $display("FAIL r_stall: s_rvalid=%b m_rready=%b, required 1/0", up.rvalid, dn.rready);
               end
               cyc();
            end
         end
         up.rready = 1'b1;
         #1;
         e = exp_r_q.pop_front();
         n_cmp++;
         if ({up.rvalid, up.rdata, up.rresp, up.rid, up.rlast} !== {1'b1, e.data, e.resp, e.id, e.last}) begin
            n_bad++;
            $display("FAIL s_r beat %0d: v=%b d=%h resp=%b id=%h last=%b, required 1 %h %b %h %b",
                     i, up.rvalid, up.rdata, up.rresp, up.rid, up.rlast, e.data, e.resp, e.id, e.last);
         end
         n_cmp++;
         if (dn.rready !== 1'b1) begin
            n_bad++; $display("FAIL m_rready beat %0d: got %b, required 1", i, dn.rready);
         end
         cyc();
         dn.rvalid = 1'b0;
         up.rready = 1'b0;
      end
      #1;
      n_cmp++;
      if (up.rvalid !== 1'b0 || dn.arvalid !== 1'b0 || up.arready !== 1'b1) begin
         n_bad++;
         $display("FAIL r_done: s_rvalid=%b m_arvalid=%b s_arready=%b, required 0/0/1",
                  up.rvalid, dn.arvalid, up.arready);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [15:0] br);
      logic [31:0] a, e_a;
      logic [71:0] ew;
      logic [5:0]  eb;
      logic [1:0]  merged, r;
      bit          ok;
      a = addr;
      merged = 2'b00;
      for (int i = 0; i <= len; i++) begin
         exp_aw_q.push_back(a);
         exp_w_q.push_back({8'hF0 ^ 8'(i), a, 32'hDEAD_0000 + 32'(i)});
         r = br[2*i +: 2];
`ifdef AXI_CAN_SPLIT_RESP_MERGE_EN
         if (merged == 2'b11 || r == 2'b11)      merged = 2'b11;
         else if (merged == 2'b10 || r == 2'b10) merged = 2'b10;
         else                                     merged = 2'b00;
`else
         merged = r;
`endif
         a = model_next(a, len, size, burst);
      end
      exp_b_q.push_back({id, merged});
      up.awid = id; up.awaddr = addr; up.awlen = 8'(len); up.awsize = 3'(size); up.awburst = burst;
      up.awvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = up.awready;
         cyc();
      end
      up.awvalid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL aw_accept: s_awready=0 for 20 cycles, required 1"); return;
      end
      for (int i = 0; i <= len; i++) begin
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            if (dn.awvalid === 1'b1) ok = 1'b1;
            else cyc();
         end
         n_cmp++;
         if (!ok) begin
            n_bad++; $display("FAIL m_awvalid_wait beat %0d: not seen in 20 cycles", i); return;
         end
         e_a = exp_aw_q.pop_front();
         n_cmp++;
         if (dn.awaddr !== e_a) begin
            n_bad++; $display("FAIL m_awaddr beat %0d: got %h, required %h", i, dn.awaddr, e_a);
         end
         n_cmp++;
         if ({dn.awid, dn.awlen, dn.awburst, dn.awsize} !== {id, 8'd0, 2'b01, 3'(size)}) begin
            n_bad++;
            $display("FAIL m_aw_ctl beat %0d: id/len/burst/size=%h/%h/%b/%0d, required %h/00/01/%0d",
                     i, dn.awid, dn.awlen, dn.awburst, dn.awsize, id, size);
         end
         dn.awready = 1'b1;
         cyc();
         dn.awready = 1'b0;
         ew = exp_w_q.pop_front();
         up.wvalid = 1'b1; up.wdata = ew[63:0]; up.wstrb = ew[71:64]; up.wlast = (i == len);
         dn.wready = 1'b1;
         #1;
         n_cmp++;
         if ({dn.awvalid, dn.wvalid, dn.wlast, dn.wstrb, dn.wdata, up.wready} !== {1'b0, 1'b1, 1'b1, ew, 1'b1}) begin
            n_bad++;
            $display("FAIL m_w beat %0d: awv=%b wv=%b wlast=%b strb=%h data=%h s_wready=%b, required 0 1 1 %h %h 1",
                     i, dn.awvalid, dn.wvalid, dn.wlast, dn.wstrb, dn.wdata, up.wready, ew[71:64], ew[63:0]);
         end
         cyc();
         up.wvalid = 1'b0;
         dn.wready = 1'b0;
         dn.bvalid = 1'b1; dn.bresp = br[2*i +: 2]; dn.bid = 4'h0;
         #1;
         n_cmp++;
         if (dn.bready !== 1'b1 || dn.wvalid !== 1'b0) begin
            n_bad++; $display("FAIL m_bready beat %0d: bready=%b wvalid=%b, required 1/0", i, dn.bready, dn.wvalid);
         end
         cyc();
         dn.bvalid = 1'b0;
      end
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (up.bvalid === 1'b1) ok = 1'b1;
         else cyc();
      end
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL s_bvalid_wait: not seen in 20 cycles"); return;
      end
      eb = exp_b_q.pop_front();
      n_cmp++;
      if ({up.bid, up.bresp} !== eb) begin
         n_bad++; $display("FAIL s_b: bid=%h bresp=%b, required %h %b", up.bid, up.bresp, eb[5:2], eb[1:0]);
      end
      up.bready = 1'b1;
      cyc();
      up.bready = 1'b0;
      n_cmp++;
      if (up.bvalid !== 1'b0 || dn.awvalid !== 1'b0 || up.awready !== 1'b1) begin
         n_bad++;
         $display("FAIL b_done: s_bvalid=%b m_awvalid=%b s_awready=%b, required 0/0/1",
                  up.bvalid, dn.awvalid, up.awready);
      end
   endtask

   task automatic test_reset();
      repeat (3) cyc();
      n_cmp++;
      if ({up.arready, up.awready, up.rvalid, up.wready, up.bvalid,
           dn.arvalid, dn.awvalid, dn.wvalid, dn.rready, dn.bready} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: arr=%b awr=%b rv=%b wr=%b bv=%b marv=%b mawv=%b mwv=%b mrr=%b mbr=%b, required all 0",
                  up.arready, up.awready, up.rvalid, up.wready, up.bvalid,
                  dn.arvalid, dn.awvalid, dn.wvalid, dn.rready, dn.bready);
      end
      rst_n = 1'b1;
      cyc();
      n_cmp++;
      if (up.arready !== 1'b1 || up.awready !== 1'b1) begin
         n_bad++; $display("FAIL idle_ready: s_arready=%b s_awready=%b, required 1/1", up.arready, up.awready);
      end
   endtask

   task automatic test_single_read();
      do_read(4'hA, 32'h2100_0008, 0, 2, 2'b01, -1, 0, 0);
   endtask

   task automatic test_incr_read();
      do_read(4'h5, 32'h2100_0010, 3, 2, 2'b01, -1, 0, 0);
   endtask

   task automatic test_wrap_read();
      do_read(4'hC, 32'h2100_0018, 3, 2, 2'b10, -1, 0, 0);
   endtask

   task automatic test_fixed_read();
      do_read(4'h2, 32'h2100_0030, 2, 3, 2'b00, -1, 0, 0);
   endtask

   task automatic test_backpressure();
      do_read(4'h7, 32'h2100_0040, 1, 2, 2'b01, 0, 5, 3);
   endtask

   task automatic test_write_merge();
      do_write(4'h6, 32'h2100_0080, 1, 3, 2'b01, 16'h0002);
      do_write(4'hE, 32'h2100_00C0, 2, 3, 2'b01, 16'h002C);
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      up.awid = 4'h9; up.awaddr = 32'h2100_0100; up.awlen = 8'd3; up.awsize = 3'd3; up.awburst = 2'b01;
      up.awvalid = 1'b1;
      cyc();
      up.awvalid = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (dn.awvalid === 1'b1) ok = 1'b1;
         else cyc();
      end
      dn.awready = 1'b1; cyc(); dn.awready = 1'b0;
      up.wvalid = 1'b1; up.wdata = 64'h1; up.wstrb = 8'hFF; dn.wready = 1'b1; cyc();
      up.wvalid = 1'b0; dn.wready = 1'b0;
      dn.bvalid = 1'b1; dn.bresp = 2'b00; cyc(); dn.bvalid = 1'b0;
      n_cmp++;
      if (!ok || dn.awvalid !== 1'b1 || dn.awaddr !== 32'h2100_0108) begin
         n_bad++; $display("FAIL mid_beat2: m_awvalid=%b m_awaddr=%h, required 1 / 21000108", dn.awvalid, dn.awaddr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({up.arready, up.awready, up.rvalid, up.wready, up.bvalid,
           dn.arvalid, dn.awvalid, dn.wvalid, dn.rready, dn.bready} !== 10'b0) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: awr=%b bv=%b mawv=%b mwv=%b mbr=%b, required all 0",
                  up.awready, up.bvalid, dn.awvalid, dn.wvalid, dn.bready);
      end
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      n_cmp++;
      if (dn.awvalid !== 1'b0 || up.bvalid !== 1'b0 || up.awready !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset_idle: m_awvalid=%b s_bvalid=%b s_awready=%b, required 0/0/1",
                  dn.awvalid, up.bvalid, up.awready);
      end
      do_write(4'h3, 32'h2100_0200, 0, 2, 2'b01, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      up.arid = '0; up.araddr = '0; up.arlen = '0; up.arsize = '0; up.arburst = '0; up.arvalid = 1'b0;
      up.rready = 1'b0;
      up.awid = '0; up.awaddr = '0; up.awlen = '0; up.awsize = '0; up.awburst = '0; up.awvalid = 1'b0;
      up.wdata = '0; up.wstrb = '0; up.wlast = 1'b0; up.wvalid = 1'b0; up.bready = 1'b0;
      dn.arready = 1'b0; dn.rid = '0; dn.rdata = '0; dn.rresp = '0; dn.rlast = 1'b0; dn.rvalid = 1'b0;
      dn.awready = 1'b0; dn.wready = 1'b0; dn.bid = '0; dn.bresp = '0; dn.bvalid = 1'b0;

      test_reset();
      test_single_read();
      test_incr_read();
      test_wrap_read();
      test_fixed_read();
      test_backpressure();
      test_write_merge();
      test_reset_mid_burst();

      n_cmp++;
      if (exp_ar_q.size() != 0 || exp_r_q.size() != 0 || exp_aw_q.size() != 0 ||
          exp_w_q.size() != 0 || exp_b_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: ar=%0d r=%0d aw=%0d w=%0d b=%0d left, required 0",
                  exp_ar_q.size(), exp_r_q.size(), exp_aw_q.size(), exp_w_q.size(), exp_b_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
